// File: rtl/ir_pipe_stage_pkg.sv
// Shared types and helpers for the instruction-register pipeline stage:
// the skid-buffer state encoding, default field positions, and the
// instruction field decoder used by the top level.
package ir_pipe_stage_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entry held
        ONE   = 2'd1,   // main entry valid
        TWO   = 2'd2    // main and skid entries valid
    } ir_state_e;

    // Default instruction format.
    localparam int IR_IW      = 16;  // instruction word width
    localparam int IR_RW      = 4;   // register specifier width
    localparam int IR_OPW     = 4;   // opcode width, field at [OPW-1:0]
    localparam int IR_RD_LSB  = 4;   // rd field position
    localparam int IR_RS1_LSB = 8;   // rs1 field position
    localparam int IR_RS2_LSB = 12;  // rs2 field position
    localparam int IR_IMM_LSB = 8;   // immediate field is [IW-1:IMM_LSB]
    localparam int IR_XLEN    = 16;  // sign-extended immediate width

    // Decoder works on a fixed wide word so one function serves every
    // parameterisation; callers keep only the low bits of each field.
    localparam int IR_MAXW = 64;

    typedef logic [IR_MAXW-1:0] ir_word_t;

    typedef struct packed {
        ir_word_t opcode;
        ir_word_t rd;
        ir_word_t rs1;
        ir_word_t rs2;
        ir_word_t imm;
    } ir_fields_t;

    // All-ones in the low 'width' bits, zero above.
    function automatic ir_word_t ir_low_mask(input int width);
        ir_word_t m;
        m = '1;
        if (width < IR_MAXW) begin
            m = ~(m << width);
        end
        return m;
    endfunction

    // Split an instruction word into its fields. Every returned field is
    // zero above its own width; imm is sign-extended from bit iw-1 and then
    // cut to xlen bits, which also covers xlen narrower than the field.
    function automatic ir_fields_t ir_field_decode(
        input ir_word_t instr,
        input int       iw      = IR_IW,
        input int       rw      = IR_RW,
        input int       opw     = IR_OPW,
        input int       rd_lsb  = IR_RD_LSB,
        input int       rs1_lsb = IR_RS1_LSB,
        input int       rs2_lsb = IR_RS2_LSB,
        input int       imm_lsb = IR_IMM_LSB,
        input int       xlen    = IR_XLEN
    );
        ir_fields_t                  f;
        ir_word_t                    top_aligned;
        logic signed [IR_MAXW-1:0]   imm_ext;

        f.opcode = instr & ir_low_mask(opw);
        f.rd     = (instr >> rd_lsb)  & ir_low_mask(rw);
        f.rs1    = (instr >> rs1_lsb) & ir_low_mask(rw);
        f.rs2    = (instr >> rs2_lsb) & ir_low_mask(rw);

        // Park the instruction's sign bit at the word MSB, then shift back
        // arithmetically so the immediate lands at bit 0 sign-extended.
        top_aligned = instr << (IR_MAXW - iw);
        imm_ext     = signed'(top_aligned) >>> (IR_MAXW - iw + imm_lsb);
        f.imm       = ir_word_t'(imm_ext) & ir_low_mask(xlen);
        return f;
    endfunction

endpackage

// File: rtl/ir_pipe_stage_skid.sv
// Two-entry skid buffer for instruction words. The main entry is what the
// consumer sees; the skid entry catches the one extra word that can arrive
// in the cycle after the consumer stalls, so the registered ready never
// loses data. Strict FIFO order, flush empties both entries.
module ir_skid_buffer
    import ir_pipe_stage_pkg::*;
#(
    parameter int IW = IR_IW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [IW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [IW-1:0] o_data,
    output logic          o_load,
    output logic [IW-1:0] o_load_data
);

    ir_state_e     r_state;
    ir_state_e     w_state_next;
    logic          r_ready;
    logic [IW-1:0] r_main;
    logic [IW-1:0] r_skid;

    logic          w_accept;
    logic          w_consume;
    logic          w_load_main;
    logic          w_main_from_skid;
    logic          w_load_skid;
    logic [IW-1:0] w_main_next;

    assign o_valid   = (r_state != EMPTY);
    assign o_ready   = r_ready;
    assign w_accept  = i_valid & r_ready;
    assign w_consume = o_valid & i_ready;

    // Next-state and load strobes; flush beats any accept or consume.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves one unassigned, which would infer a latch.
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_main  = 1'b1;
                        w_state_next = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_state_next = TWO;
                    end else if (w_consume) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    // Ready is low here, so only the drain move can happen.
                    if (w_consume) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_next     = ONE;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign w_main_next = w_main_from_skid ? r_skid : i_data;

    // State register; ready is registered from the next state.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != TWO);
        end
    end

    // Entry storage; cleared on reset and flush so the held word reads zero.
    always_ff @(posedge clock) begin
        // NOTE: the two data entries are reset deliberately, because the
        // raw held word is a visible output that must read zero after reset.
        if (reset || i_flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_main_next;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_data      = r_main;
    assign o_load      = w_load_main;
    assign o_load_data = w_main_next;

endmodule

// File: rtl/ir_pipe_stage.sv
// Instruction register between fetch and register-file read. A two-entry
// skid buffer absorbs back-pressure; the decoded fields are registered in
// the same edge that loads the main entry, so every output is a flop.
module ir_pipe_stage
    import ir_pipe_stage_pkg::*;
#(
    parameter int IW      = IR_IW,
    parameter int RW      = IR_RW,
    parameter int OPW     = IR_OPW,
    parameter int RD_LSB  = IR_RD_LSB,
    parameter int RS1_LSB = IR_RS1_LSB,
    parameter int RS2_LSB = IR_RS2_LSB,
    parameter int IMM_LSB = IR_IMM_LSB,
    parameter int XLEN    = IR_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [IW-1:0]   in_instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   rs1,
    output logic [RW-1:0]   rs2,
    output logic [RW-1:0]   rd,
    output logic [OPW-1:0]  opcode,
    output logic [XLEN-1:0] imm,
    output logic [IW-1:0]   instr
);

    logic            w_load;
    logic [IW-1:0]   w_load_data;
    ir_fields_t      w_fields;

    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic [OPW-1:0]  r_opcode;
    logic [XLEN-1:0] r_imm;

    ir_skid_buffer #(
        .IW (IW)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .i_data      (in_instr),
        .o_ready     (in_ready),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (instr),
        .o_load      (w_load),
        .o_load_data (w_load_data)
    );

    // Decode the word that is about to become the main entry.
    always_comb begin
        w_fields = ir_field_decode(ir_word_t'(w_load_data), IW, RW, OPW,
                                   RD_LSB, RS1_LSB, RS2_LSB, IMM_LSB, XLEN);
    end

    // The decoder masks each field to its own width, so bits above it are
    // always zero.
    always_comb begin
        assert (((w_fields.opcode >> OPW) | (w_fields.rd >> RW) |
                 (w_fields.rs1 >> RW) | (w_fields.rs2 >> RW) |
                 (w_fields.imm >> XLEN)) == '0);
    end

    // Field register: loads alongside the main entry, clears on reset/flush,
    // otherwise holds (including while the stage is empty).
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_opcode <= '0;
            r_imm    <= '0;
        end else if (w_load) begin
            r_rs1    <= w_fields.rs1[RW-1:0];
            r_rs2    <= w_fields.rs2[RW-1:0];
            r_rd     <= w_fields.rd[RW-1:0];
            r_opcode <= w_fields.opcode[OPW-1:0];
            r_imm    <= w_fields.imm[XLEN-1:0];
        end
    end

    assign rs1    = r_rs1;
    assign rs2    = r_rs2;
    assign rd     = r_rd;
    assign opcode = r_opcode;
    assign imm    = r_imm;

endmodule
